// File: rtl/mul_pkg.sv
// Shared types and constants for the shift-add multiplier.
// Used by shift_add_multiplier and mul_datapath.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  localparam int unsigned MUL_DEFAULT_WIDTH = 32;

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/mul_datapath.sv
// Operand/accumulator registers, shifter, adder and overflow logic for the multiplier.
// Macro MUL_SIGNED_EN adds the signed_mode input (two's complement via sign-magnitude).
module mul_datapath
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_DEFAULT_WIDTH,
  localparam int unsigned P_W = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef MUL_SIGNED_EN
  input  logic             signed_mode,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             load,
  input  logic             zero_load,
  input  logic             step,
  input  logic             last,
  output logic             op_zero,
  output logic [P_W-1:0]   p,
  output logic             ovf
);

  logic             sgn;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             neg_in;

`ifdef MUL_SIGNED_EN
  assign sgn = signed_mode;
`else
  assign sgn = 1'b0;
`endif

  assign op_zero = (a == '0) || (b == '0);
  // Magnitudes fit in WIDTH unsigned bits, including the most negative value.
  assign a_mag   = (sgn && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_mag   = (sgn && b[WIDTH-1]) ? (~b + 1'b1) : b;
  assign neg_in  = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);

  logic [P_W-1:0]   mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [P_W-1:0]   acc_q;
  logic             neg_q;
  logic             sgn_q;
  logic [P_W-1:0]   p_q;
  logic             ovf_q;

  logic [P_W-1:0]   addend;
  logic [P_W-1:0]   sum;
  logic [P_W-1:0]   result;
  logic             ovf_next;

  always_comb begin
    addend = mplier_q[0] ? mcand_q : '0;
    sum    = acc_q + addend;
    result = neg_q ? (~sum + 1'b1) : sum;
    if (sgn_q) begin
      ovf_next = !((&result[P_W-1:WIDTH-1]) || !(|result[P_W-1:WIDTH-1]));
    end else begin
      ovf_next = |result[P_W-1:WIDTH];
    end
  end

  // p/ovf are registered on entry to DONE so they are already valid in the done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      sgn_q    <= 1'b0;
      p_q      <= '0;
      ovf_q    <= 1'b0;
    end else if (zero_load) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      sgn_q    <= sgn;
      p_q      <= '0;
      ovf_q    <= 1'b0;
    end else if (load) begin
      mcand_q  <= {{WIDTH{1'b0}}, a_mag};
      mplier_q <= b_mag;
      acc_q    <= '0;
      neg_q    <= neg_in;
      sgn_q    <= sgn;
    end else if (step) begin
      acc_q    <= sum;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (last) begin
        p_q   <= result;
        ovf_q <= ovf_next;
      end
    end
  end

  assign p   = p_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, zero-operand shortcut.
// Macro MUL_SIGNED_EN adds the signed_mode input for two's complement operands.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_DEFAULT_WIDTH,
  localparam int unsigned P_W = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef MUL_SIGNED_EN
  input  logic             signed_mode,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [P_W-1:0]   p,
  output logic             ovf
);

  localparam int unsigned CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mul_state_e       state_q;
  mul_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic accept;
  logic op_zero;
  logic load;
  logic zero_load;
  logic step;
  logic last;

  assign accept    = (state_q == IDLE) && start;
  assign load      = accept && !op_zero;
  assign zero_load = accept && op_zero;
  assign step      = (state_q == CALC);
  assign last      = step && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = op_zero ? DONE : CALC;
          cnt_d   = '0;
        end
      end
      CALC: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  mul_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef MUL_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .a          (a),
    .b          (b),
    .load       (load),
    .zero_load  (zero_load),
    .step       (step),
    .last       (last),
    .op_zero    (op_zero),
    .p          (p),
    .ovf        (ovf)
  );

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomised self-checking bench for shift_add_multiplier (WIDTH=8 and WIDTH=32 instances).
// Define MUL_SIGNED_EN to also exercise signed_mode.
module tb_shift_add_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start8;
  logic        sm8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [15:0] p8;
  logic        ovf8;

  logic        start32;
  logic [31:0] a32;
  logic [31:0] b32;
  logic        busy32;
  logic        done32;
  logic [63:0] p32;
  logic        ovf32;

  shift_add_multiplier #(
    .WIDTH(8)
  ) u_dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start8),
`ifdef MUL_SIGNED_EN
    .signed_mode(sm8),
`endif
    .a          (a8),
    .b          (b8),
    .busy       (busy8),
    .done       (done8),
    .p          (p8),
    .ovf        (ovf8)
  );

  shift_add_multiplier #(
    .WIDTH(32)
  ) u_dut32 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start32),
`ifdef MUL_SIGNED_EN
    .signed_mode(1'b0),
`endif
    .a          (a32),
    .b          (b32),
    .busy       (busy32),
    .done       (done32),
    .p          (p32),
    .ovf        (ovf32)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          done_cnt8 = 0;

  always @(negedge clk) if (done8) done_cnt8++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer multiply; returns {ovf, product}.
  function automatic logic [16:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic sm);
    int xv, yv, prod;
    logic o;
    xv   = (sm && x[7]) ? int'(x) - 256 : int'(x);
    yv   = (sm && y[7]) ? int'(y) - 256 : int'(y);
    prod = xv * yv;
    if (sm) o = (prod > 127) || (prod < -128);
    else    o = (prod > 255);
    return {o, 16'(prod)};
  endfunction

  // One 8-bit operation; optional one-cycle start poke while busy. Returns done latency.
  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic sm,
                      input int poke_at, output int lat);
    int cyc;
    @(negedge clk);
    start8 = 1'b1;
    a8     = x;
    b8     = y;
    sm8    = sm;
    cyc    = 0;
    do begin
      @(negedge clk);
      cyc++;
      start8 = (cyc == poke_at);
      if (cyc == poke_at) begin
        a8 = 8'd2;
        b8 = 8'd2;
      end else begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
      end
    end while (!done8 && cyc < 100);
    lat = cyc;
  endtask

  // Full check of one 8-bit operation against the reference model.
  task automatic op8(input string tag, input logic [7:0] x, input logic [7:0] y, input logic sm,
                     input int poke_at);
    int lat, dc0;
    logic [16:0] e;
    e   = ref8(x, y, sm);
    dc0 = done_cnt8;
    run8(x, y, sm, poke_at, lat);
    check_eq({tag, "_lat"}, 64'(lat), ((x == 0) || (y == 0)) ? 64'd1 : 64'd9);
    check_eq({tag, "_p"}, 64'(p8), 64'(e[15:0]));
    check_eq({tag, "_ovf"}, 64'(ovf8), 64'(e[16]));
    @(negedge clk);
    check_eq({tag, "_done_once"}, 64'(done_cnt8 - dc0), 64'd1);
    check_eq({tag, "_p_hold"}, 64'(p8), 64'(e[15:0]));
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic        rs;
    logic [63:0] e32;
    int          cyc, dc0;

    rst_n   = 1'b0;
    start8  = 1'b0;
    sm8     = 1'b0;
    a8      = '0;
    b8      = '0;
    start32 = 1'b0;
    a32     = '0;
    b32     = '0;
    repeat (2) @(negedge clk);
    check_eq("reset_busy", 64'(busy8), 64'd0);
    check_eq("reset_done", 64'(done8), 64'd0);
    check_eq("reset_p", 64'(p8), 64'd0);
    check_eq("reset_ovf", 64'(ovf8), 64'd0);
    rst_n = 1'b1;

    op8("mul_13x11", 8'd13, 8'd11, 1'b0, -1);
    op8("mul_255x255", 8'd255, 8'd255, 1'b0, -1);
    op8("zero_a", 8'd0, 8'd200, 1'b0, -1);
    op8("busy_poke", 8'd13, 8'd11, 1'b0, 3);

    // Reset in the middle of a calculation.
    op8("pre_abort", 8'd200, 8'd3, 1'b0, -1);
    @(negedge clk);
    start8 = 1'b1;
    a8     = 8'd13;
    b8     = 8'd11;
    repeat (4) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    check_eq("abort_busy_before", 64'(busy8), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", 64'(busy8), 64'd0);
    check_eq("abort_done", 64'(done8), 64'd0);
    check_eq("abort_p", 64'(p8), 64'd0);
    check_eq("abort_ovf", 64'(ovf8), 64'd0);
    dc0 = done_cnt8;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check_eq("abort_no_done", 64'(done_cnt8 - dc0), 64'd0);
    check_eq("abort_p_after", 64'(p8), 64'd0);
    op8("after_abort", 8'd13, 8'd11, 1'b0, -1);

`ifdef MUL_SIGNED_EN
    op8("s_m3x5", 8'hFD, 8'd5, 1'b1, -1);
    op8("s_m128xm128", 8'h80, 8'h80, 1'b1, -1);
`endif

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 8'd0;
      if ($urandom_range(0, 7) == 0) rb = 8'd0;
`ifdef MUL_SIGNED_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      op8("rand", ra, rb, rs, ((i % 5) == 0) ? 2 : -1);
    end

    // Full-width WIDTH=32 run.
    e32 = 64'(32'hFFFF_FFFF) * 64'(32'hFFFF_FFFF);
    @(negedge clk);
    start32 = 1'b1;
    a32     = 32'hFFFF_FFFF;
    b32     = 32'hFFFF_FFFF;
    cyc     = 0;
    do begin
      @(negedge clk);
      cyc++;
      start32 = 1'b0;
      a32     = $urandom;
      b32     = $urandom;
    end while (!done32 && cyc < 100);
    check_eq("w32_lat", 64'(cyc), 64'd33);
    check_eq("w32_p", p32, e32);
    check_eq("w32_ovf", 64'(ovf32), 64'd1);
    @(negedge clk);
    check_eq("w32_busy_after", 64'(busy32), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
